// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for alu_arbiter: FSM states, ALU op codes, request payload.
package alu_arb_pkg;

  localparam int ALU_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_OR   = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_RSV0 = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SUB  = 4'd6;
  localparam logic [3:0] OP_SLT  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLL  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_SRA  = 4'd11;
  localparam logic [3:0] OP_SLLV = 4'd12;
  localparam logic [3:0] OP_SRLV = 4'd13;
  localparam logic [3:0] OP_SRAV = 4'd14;
  localparam logic [3:0] OP_RSV1 = 4'd15;

  typedef struct packed {
    logic [3:0]       op;
    logic [ALU_W-1:0] srca;
    logic [ALU_W-1:0] srcb;
    logic [4:0]       shamt;
    logic             ovf_chk;
  } req_t;

  function automatic logic is_reserved(input logic [3:0] op);
    return (op == OP_RSV0) || (op == OP_RSV1);
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester-side request/response handshake bundle for alu_arbiter.
interface alu_arbiter_if #(parameter int DATA_W = 32);
  logic              req0_valid, req0_ready, req0_ovf_chk;
  logic [3:0]        req0_op;
  logic [DATA_W-1:0] req0_srca, req0_srcb;
  logic [4:0]        req0_shamt;
  logic              req1_valid, req1_ready, req1_ovf_chk;
  logic [3:0]        req1_op;
  logic [DATA_W-1:0] req1_srca, req1_srcb;
  logic [4:0]        req1_shamt;
  logic              rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [DATA_W-1:0] rsp_res;
  logic              rsp_zero, rsp_ovf;

  modport master (
    output req0_valid, req0_op, req0_srca, req0_srcb, req0_shamt, req0_ovf_chk,
    output req1_valid, req1_op, req1_srca, req1_srcb, req1_shamt, req1_ovf_chk,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_ovf,
    output rsp0_ready, rsp1_ready
  );

  modport slave (
    input  req0_valid, req0_op, req0_srca, req0_srcb, req0_shamt, req0_ovf_chk,
    input  req1_valid, req1_op, req1_srca, req1_srcb, req1_shamt, req1_ovf_chk,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_res, rsp_zero, rsp_ovf,
    input  rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time is chosen.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       gnt_id
);
  always_comb begin
    any    = |valid;
    gnt_id = (valid == 2'b11) ? ~last_grant : valid[1];
  end
endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters (IDLE -> EXEC -> RESP per operation).
// Optional grant counters enabled by defining ALU_ARB_STATS_EN.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int DATA_W = 32
`ifdef ALU_ARB_STATS_EN
  , parameter int STATS_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_arbiter_if.slave      bus,
  output logic [3:0]        alu_op_code,
  output logic [DATA_W-1:0] alu_srca,
  output logic [DATA_W-1:0] alu_srcb,
  output logic [4:0]        alu_shamt,
  output logic              alu_overflow_check,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_zero_flag,
  input  logic              alu_overflow,
  output logic              busy
`ifdef ALU_ARB_STATS_EN
  , input  logic             stats_clr
  , output logic [STATS_W-1:0] grant_cnt0
  , output logic [STATS_W-1:0] grant_cnt1
`endif
);

  state_t state, next_state;
  logic   last_grant, cur, grant, gnt_id, any_valid;
  req_t   op_q, sel_req;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant),
    .any        (any_valid),
    .gnt_id     (gnt_id)
  );

  always_comb begin
    sel_req = gnt_id
      ? '{op: bus.req1_op, srca: bus.req1_srca, srcb: bus.req1_srcb,
          shamt: bus.req1_shamt, ovf_chk: bus.req1_ovf_chk}
      : '{op: bus.req0_op, srca: bus.req0_srca, srcb: bus.req0_srcb,
          shamt: bus.req0_shamt, ovf_chk: bus.req0_ovf_chk};
  end

  always_comb begin
    next_state     = state;
    grant          = 1'b0;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    case (state)
      IDLE: if (any_valid) begin
        grant          = 1'b1;
        bus.req0_ready = ~gnt_id;
        bus.req1_ready = gnt_id;
        next_state     = EXEC;
      end
      EXEC: next_state = RESP;
      RESP: if (cur ? bus.rsp1_ready : bus.rsp0_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    bus.rsp0_valid = (state == RESP) && !cur;
    bus.rsp1_valid = (state == RESP) && cur;
    busy           = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      cur          <= 1'b0;
      op_q         <= '0;
      bus.rsp_res  <= '0;
      bus.rsp_zero <= 1'b0;
      bus.rsp_ovf  <= 1'b0;
    end else begin
      state <= next_state;
      if (grant) begin
        op_q       <= sel_req;
        last_grant <= gnt_id;
        cur        <= gnt_id;
      end
      if (state == EXEC) begin
        // Reserved ops never trust the ALU: force a clean zero result.
        if (is_reserved(op_q.op)) begin
          bus.rsp_res  <= '0;
          bus.rsp_zero <= 1'b1;
          bus.rsp_ovf  <= 1'b0;
        end else begin
          bus.rsp_res  <= alu_res;
          bus.rsp_zero <= alu_zero_flag;
          bus.rsp_ovf  <= alu_overflow;
        end
      end
    end
  end

  always_comb begin
    alu_op_code        = op_q.op;
    alu_srca           = op_q.srca;
    alu_srcb           = op_q.srcb;
    alu_shamt          = op_q.shamt;
    alu_overflow_check = op_q.ovf_chk;
  end

`ifdef ALU_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (stats_clr) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
    end else if (grant) begin
      if (!gnt_id && grant_cnt0 != '1) grant_cnt0 <= grant_cnt0 + 1'b1;
      if (gnt_id && grant_cnt1 != '1)  grant_cnt1 <= grant_cnt1 + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter with a small behavioural ALU.
// Define ALU_ARB_STATS_EN to also exercise the grant counters.
module tb_alu_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  alu_op_code;
  logic [31:0] alu_srca, alu_srcb, alu_res;
  logic [4:0]  alu_shamt;
  logic        alu_overflow_check, alu_zero_flag, alu_overflow, busy;
`ifdef ALU_ARB_STATS_EN
  logic        stats_clr;
  logic [15:0] grant_cnt0, grant_cnt1;
`endif
  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DATA_W(32)) bus ();

  alu_arbiter #(.DATA_W(32)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .bus                (bus),
    .alu_op_code        (alu_op_code),
    .alu_srca           (alu_srca),
    .alu_srcb           (alu_srcb),
    .alu_shamt          (alu_shamt),
    .alu_overflow_check (alu_overflow_check),
    .alu_res            (alu_res),
    .alu_zero_flag      (alu_zero_flag),
    .alu_overflow       (alu_overflow),
    .busy               (busy)
`ifdef ALU_ARB_STATS_EN
    , .stats_clr        (stats_clr)
    , .grant_cnt0       (grant_cnt0)
    , .grant_cnt1       (grant_cnt1)
`endif
  );

  // Behavioural ALU; unknown/reserved ops return garbage with overflow set.
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_op_code)
      4'd0: alu_res = alu_srca & alu_srcb;
      4'd1: alu_res = alu_srca | alu_srcb;
      4'd2: begin
        alu_res = alu_srca + alu_srcb;
        alu_overflow = alu_overflow_check && (alu_srca[31] == alu_srcb[31]) && (alu_res[31] != alu_srca[31]);
      end
      4'd4: alu_res = alu_srca ^ alu_srcb;
      4'd6: alu_res = alu_srca - alu_srcb;
      default: begin
        alu_res = 32'hDEAD_BEEF;
        alu_overflow = 1'b1;
      end
    endcase
    alu_zero_flag = (alu_res == 32'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input bit who, input logic v, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic ovf);
    if (!who) begin
      bus.req0_valid = v; bus.req0_op = op; bus.req0_srca = a;
      bus.req0_srcb = b; bus.req0_shamt = sh; bus.req0_ovf_chk = ovf;
    end else begin
      bus.req1_valid = v; bus.req1_op = op; bus.req1_srca = a;
      bus.req1_srcb = b; bus.req1_shamt = sh; bus.req1_ovf_chk = ovf;
    end
  endtask

  // Full single-requester transaction from IDLE: grant, EXEC, RESP, consume.
  task automatic do_op(input string tag, input bit who, input logic [3:0] op,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic ovf, input logic [31:0] er, input logic ez, input logic eo);
    drive_req(who, 1'b1, op, a, b, sh, ovf);
    #1;
    check({tag, ".ready"}, who ? bus.req1_ready : bus.req0_ready, 32'd1);
    check({tag, ".other_ready"}, who ? bus.req0_ready : bus.req1_ready, 32'd0);
    tick();
    if (!who) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
    check({tag, ".busy"}, busy, 32'd1);
    check({tag, ".early_valid"}, who ? bus.rsp1_valid : bus.rsp0_valid, 32'd0);
    check({tag, ".alu_op"}, alu_op_code, op);
    check({tag, ".alu_a"}, alu_srca, a);
    check({tag, ".alu_b"}, alu_srcb, b);
    check({tag, ".alu_sh"}, alu_shamt, sh);
    check({tag, ".alu_ochk"}, alu_overflow_check, ovf);
    tick();
    check({tag, ".rsp_valid"}, who ? bus.rsp1_valid : bus.rsp0_valid, 32'd1);
    check({tag, ".res"}, bus.rsp_res, er);
    check({tag, ".zero"}, bus.rsp_zero, ez);
    check({tag, ".ovf"}, bus.rsp_ovf, eo);
    if (!who) bus.rsp0_ready = 1'b1; else bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
    check({tag, ".rsp_clear"}, who ? bus.rsp1_valid : bus.rsp0_valid, 32'd0);
    check({tag, ".idle"}, busy, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0, 5'd0, 1'b0);
    bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b0;
`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    tick(); tick();
    check("rst.busy", busy, 32'd0);
    check("rst.rsp0_valid", bus.rsp0_valid, 32'd0);
    check("rst.rsp1_valid", bus.rsp1_valid, 32'd0);
    check("rst.res", bus.rsp_res, 32'd0);
    check("rst.alu_op", alu_op_code, 32'd0);
    check("rst.alu_a", alu_srca, 32'd0);
    rst_n = 1'b1;
    tick();

    do_op("add0", 1'b0, 4'd2, 32'd5, 32'd7, 5'd17, 1'b0, 32'd12, 1'b0, 1'b0);
    do_op("ovf1", 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 32'h8000_0000, 1'b0, 1'b1);
    do_op("novf1", 1'b1, 4'd2, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b0, 32'h8000_0000, 1'b0, 1'b0);
    do_op("rsv0", 1'b0, 4'd3, 32'd1, 32'd2, 5'd4, 1'b1, 32'd0, 1'b1, 1'b0);
    do_op("rsv1", 1'b1, 4'd15, 32'd6, 32'd6, 5'd1, 1'b0, 32'd0, 1'b1, 1'b0);
    do_op("sub0", 1'b0, 4'd6, 32'd9, 32'd9, 5'd0, 1'b0, 32'd0, 1'b1, 1'b0);

    // Back-pressure: rsp0 held while req1 waits.
    drive_req(1'b0, 1'b1, 4'd4, 32'hF0, 32'hFF, 5'd0, 1'b0);
    #1 check("bp.grant0", bus.req0_ready, 32'd1);
    tick();
    bus.req0_valid = 1'b0;
    drive_req(1'b1, 1'b1, 4'd1, 32'd1, 32'd2, 5'd0, 1'b0);
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp.valid", bus.rsp0_valid, 32'd1);
      check("bp.res", bus.rsp_res, 32'h0F);
      check("bp.busy", busy, 32'd1);
      check("bp.no_grant1", bus.req1_ready, 32'd0);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1 check("bp.release_no_grant", bus.req1_ready, 32'd0);
    tick();
    bus.rsp0_ready = 1'b0;
    #1 check("bp.grant1", bus.req1_ready, 32'd1);
    check("bp.rsp0_clear", bus.rsp0_valid, 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("bp.rsp1_valid", bus.rsp1_valid, 32'd1);
    check("bp.rsp1_res", bus.rsp_res, 32'd3);
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;

    // Reset while EXEC.
    drive_req(1'b1, 1'b1, 4'd0, 32'hFF, 32'h0F, 5'd9, 1'b1);
    tick();
    bus.req1_valid = 1'b0;
    check("mid.busy_pre", busy, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.busy", busy, 32'd0);
    check("mid.alu_a", alu_srca, 32'd0);
    check("mid.alu_op", alu_op_code, 32'd0);
    check("mid.res", bus.rsp_res, 32'd0);
    check("mid.rsp1_valid", bus.rsp1_valid, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // Contention after reset: req0 first, then alternate.
    drive_req(1'b0, 1'b1, 4'd2, 32'd1, 32'd1, 5'd0, 1'b0);
    drive_req(1'b1, 1'b1, 4'd2, 32'd2, 32'd2, 5'd0, 1'b0);
    #1;
    check("tie1.req0", bus.req0_ready, 32'd1);
    check("tie1.req1", bus.req1_ready, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("tie1.rsp0", bus.rsp0_valid, 32'd1);
    check("tie1.res", bus.rsp_res, 32'd2);
    bus.rsp0_ready = 1'b1;
    drive_req(1'b0, 1'b1, 4'd2, 32'd3, 32'd3, 5'd0, 1'b0);
    tick();
    bus.rsp0_ready = 1'b0;
    #1;
    check("tie2.req1", bus.req1_ready, 32'd1);
    check("tie2.req0", bus.req0_ready, 32'd0);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("tie2.rsp1", bus.rsp1_valid, 32'd1);
    check("tie2.res", bus.rsp_res, 32'd4);
    bus.rsp1_ready = 1'b1;
    drive_req(1'b1, 1'b1, 4'd2, 32'd5, 32'd5, 5'd0, 1'b0);
    tick();
    bus.rsp1_ready = 1'b0;
    #1;
    check("tie3.req0", bus.req0_ready, 32'd1);
    check("tie3.req1", bus.req1_ready, 32'd0);
    tick();
    bus.req0_valid = 1'b0;
    tick();
    check("tie3.res", bus.rsp_res, 32'd6);
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
    #1 check("tie4.req1", bus.req1_ready, 32'd1);
    tick();
    bus.req1_valid = 1'b0;
    tick();
    check("tie4.res", bus.rsp_res, 32'd10);
    bus.rsp1_ready = 1'b1;
    tick();
    bus.rsp1_ready = 1'b0;

`ifdef ALU_ARB_STATS_EN
    stats_clr = 1'b1;
    tick();
    stats_clr = 1'b0;
    check("st.clr0", grant_cnt0, 32'd0);
    check("st.clr1", grant_cnt1, 32'd0);
    for (int i = 0; i < 3; i++)
      do_op("st.op", 1'b0, 4'd1, 32'd8, 32'd1, 5'd0, 1'b0, 32'd9, 1'b0, 1'b0);
    check("st.cnt0", grant_cnt0, 32'd3);
    check("st.cnt1", grant_cnt1, 32'd0);
    drive_req(1'b0, 1'b1, 4'd1, 32'd0, 32'd0, 5'd0, 1'b0);
    stats_clr = 1'b1;
    #1 check("st.grant_with_clr", bus.req0_ready, 32'd1);
    tick();
    stats_clr = 1'b0;
    bus.req0_valid = 1'b0;
    check("st.clr_wins", grant_cnt0, 32'd0);
    tick();
    bus.rsp0_ready = 1'b1;
    tick();
    bus.rsp0_ready = 1'b0;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one 32-bit combinational ALU between two requesters: requester 0 is the integer datapath, requester 1 is the address/branch unit.
- Round-robin arbitration, valid/ready request and response handshakes.
- Operands are registered before they drive the ALU. ALU outputs are captured into a response buffer.
- Sits between the requesters and the single ALU instance, so all ALU sequencing lives in one place.

Parameters:
- DATA_W, 32, operand/result width; must match the ALU (only 32 supported).
- STATS_W, 16, width of grant counters (optional feature only).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqN_valid  in  1  request N valid (N = 0, 1).
- reqN_ready  out  1  request N accepted this cycle.
- reqN_op  in  4  ALU op code.
- reqN_srca  in  DATA_W  operand A.
- reqN_srcb  in  DATA_W  operand B.
- reqN_shamt  in  5  shift amount.
- reqN_ovf_chk  in  1  enable overflow detection.
- rspN_valid  out  1  response for requester N valid.
- rspN_ready  in  1  requester N consumes the response.
- rsp_res  out  DATA_W  result (shared by both requesters; qualified by rspN_valid).
- rsp_zero  out  1  zero flag.
- rsp_ovf  out  1  overflow flag.
- alu_op_code  out  4  to ALU.
- alu_srca  out  DATA_W  to ALU.
- alu_srcb  out  DATA_W  to ALU.
- alu_shamt  out  5  to ALU.
- alu_overflow_check  out  1  to ALU.
- alu_res  in  DATA_W  from ALU.
- alu_zero_flag  in  1  from ALU.
- alu_overflow  in  1  from ALU.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all ALU-side registers 0; rsp_res 0; rsp_zero 0; rsp_ovf 0; rspN_valid 0; last_grant=1, so requester 0 wins the first tie. Any in-flight operation is discarded and the requester must reissue.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If no reqN_valid, stay in IDLE.
  - If exactly one valid, grant it.
  - If both valid, grant the requester that is not last_grant.
  - On grant: reqN_ready=1 combinationally for that cycle only; latch op, srca, srcb, shamt, ovf_chk into the ALU-side registers; update last_grant; go to EXEC.
  - reqN_ready is 0 in every other state.
- EXEC: the ALU is driven from the registered operands. At the end of the cycle capture alu_res, alu_zero_flag and alu_overflow into the rsp registers; go to RESP.
- Reserved op codes 4'b0011 and 4'b1111: do not use the ALU outputs; capture rsp_res=0, rsp_zero=1, rsp_ovf=0.
- RESP: rspN_valid=1 for the granted N only. Response data is stable while valid. When rspN_ready=1, clear valid and return to IDLE.
- Timing: accept at cycle t, rspN_valid high at t+2. Minimum 3 cycles per operation; no back-to-back overlap.
- Requesters hold valid and payload stable until ready. The arbiter does not check this.
- A request arriving while busy waits; a waiting requester is granted at most one operation after the current one (starvation-free).
- ALU-side outputs hold their last value in IDLE and RESP. rsp_res is not cleared on response consumption.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- When defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (STATS_W each) and input stats_clr.
  - Each counter increments on its requester's grant and saturates at all-ones.
  - stats_clr (synchronous) zeroes both counters; clear wins over a simultaneous increment.
  - Counters reset to 0 on rst_n.
- When undefined: these ports and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Shared package alu_arb_pkg holds:
  - state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2;
  - ALU op code constants: AND=0, OR=1, ADD=2, XOR=4, NOR=5, SUB=6, SLT=7, SLTU=8, SLL=9, SRL=10, SRA=11, SLLV=12, SRLV=13, SRAV=14, RSV0=3, RSV1=15;
  - a request struct (op, srca, srcb, shamt, ovf_chk).
- One natural sub-module, rr_arb2: 2-way round-robin grant from valid bits and last_grant.

Test Plan:
- Reset and single request: reset, then req0 ADD srca=5 srcb=7 at t -> req0_ready at t; rsp0_valid at t+2 with rsp_res=12, zero=0, ovf=0.
- Contention after reset: req0 and req1 valid together -> req0 granted first; req1 granted on the next IDLE; grants alternate while both stay valid.
- Overflow: req1 ADD 0x7FFFFFFF+1 with ovf_chk=1 -> rsp_ovf=1, rsp_res=0x80000000. Same with ovf_chk=0 -> rsp_ovf=0.
- Response back-pressure: hold rsp0_ready=0 for 5 cycles -> rsp0_valid and data stable, busy=1, req1 not granted; release -> IDLE, then req1 granted.
- Reserved op 4'b0011 -> rsp_res=0, zero=1, ovf=0. SUB 9-9 -> zero=1.
- Reset mid-operation: assert rst_n=0 in EXEC -> outputs go to reset values immediately; after release, req0 wins a tie. With ALU_ARB_STATS_EN: 3 grants to req0 -> grant_cnt0=3; stats_clr plus a simultaneous grant -> 0.
